// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit tiny CPU.
// Owns the PC, instruction register, memory handshakes, write strobes and branch resolution.
module cpu_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instruction,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        flag_write,
  input  logic        is_branch,
  input  logic [3:0]  branch_type,
  input  logic [15:0] branch_offset,
  input  logic        zero_flag,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        reg_we,
  output logic        flag_we,
  output logic [15:0] pc,
  output logic [2:0]  state,
  output logic [15:0] retired,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_instr;
  logic [15:0] r_retired;
  logic [7:0]  r_wait;
  logic        r_imem_req;
  logic        r_dmem_req;
  logic        r_dmem_we;
  logic        r_reg_we;
  logic        r_flag_we;
  logic        r_bus_err;
  logic        w_taken;
  logic        w_wait_last;

  always_comb begin
    w_taken = 1'b0;
    case (branch_type)
      4'b1001: w_taken = 1'b1;
      4'b1010: w_taken = zero_flag;
      4'b1011: w_taken = !zero_flag;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_wait_last = (r_wait == WAIT_LAST);

  // Every strobe is registered on the transition into the state where it must be seen,
  // so a request is already high in the first FETCH/MEM cycle without any ack->req path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_instr    <= 16'h0000;
      r_retired  <= 16'h0000;
      r_wait     <= 8'd0;
      r_imem_req <= 1'b0;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_reg_we   <= 1'b0;
      r_flag_we  <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_reg_we  <= 1'b0;
      r_flag_we <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (!r_imem_req) begin
            r_imem_req <= !stall;
          end else if (imem_ack) begin
            r_instr    <= imem_rdata;
            r_pc       <= r_pc + 16'd1;
            r_imem_req <= 1'b0;
            r_wait     <= 8'd0;
            r_state    <= S_DECODE;
          end else if (w_wait_last) begin
            r_bus_err  <= 1'b1;
            r_imem_req <= 1'b0;
            r_wait     <= 8'd0;
            r_state    <= S_HALT;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_DECODE: begin
          // ControlUnit outputs have settled on the new instruction by now.
          r_flag_we <= flag_write;
          r_state   <= S_EXEC;
        end
        S_EXEC: begin
          if (is_branch) begin
            if (w_taken) r_pc <= r_pc + branch_offset;
            r_retired  <= r_retired + 16'd1;
            r_imem_req <= !stall;
            r_state    <= S_FETCH;
          end else if (mem_read || mem_write) begin
            r_dmem_req <= 1'b1;
            r_dmem_we  <= mem_write;
            r_state    <= S_MEM;
          end else if (reg_write) begin
            r_reg_we <= 1'b1;
            r_state  <= S_WB;
          end else begin
            r_retired  <= r_retired + 16'd1;
            r_imem_req <= !stall;
            r_state    <= S_FETCH;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_wait     <= 8'd0;
            if (r_dmem_we) begin
              r_retired  <= r_retired + 16'd1;
              r_imem_req <= !stall;
              r_state    <= S_FETCH;
            end else begin
              r_reg_we <= 1'b1;
              r_state  <= S_WB;
            end
          end else if (w_wait_last) begin
            r_bus_err  <= 1'b1;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_wait     <= 8'd0;
            r_state    <= S_HALT;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_WB: begin
          r_retired  <= r_retired + 16'd1;
          r_imem_req <= !stall;
          r_state    <= S_FETCH;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_HALT;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign instruction = r_instr;
  assign dmem_req    = r_dmem_req;
  assign dmem_we     = r_dmem_we;
  assign reg_we      = r_reg_we;
  assign flag_we     = r_flag_we;
  assign pc          = r_pc;
  assign state       = r_state;
  assign retired     = r_retired;
  assign bus_err     = r_bus_err;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: acts as instruction/data memory and ControlUnit, checks
// a vector table, hand-written corner sequences, and random instructions against a model.
module tb_cpu_sequencer;

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_CMP = 3, K_BR = 4;

  typedef struct {
    int          kind;
    logic [3:0]  btype;
    logic [15:0] off;
    logic        zf;
    logic        fw;
    logic        xrw;
    int          idly;
    int          ddly;
    logic [15:0] rdata;
    logic [15:0] exp_pc;
    int          exp_lat;
    int          exp_rwe;
    int          exp_fwe;
    int          exp_dcyc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, stall;
  logic        imem_req, imem_ack;
  logic [15:0] imem_addr, imem_rdata, instruction;
  logic        reg_write, mem_read, mem_write, flag_write, is_branch, zero_flag;
  logic [3:0]  branch_type;
  logic [15:0] branch_offset;
  logic        dmem_req, dmem_we, dmem_ack, reg_we, flag_we, bus_err;
  logic [15:0] pc, retired;
  logic [2:0]  state;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_pc;
  logic [15:0] m_ret;
  vec_t        tbl[15];

  cpu_sequencer #(.RESET_PC(16'h0000), .MAX_WAIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .flag_write(flag_write),
    .is_branch(is_branch), .branch_type(branch_type), .branch_offset(branch_offset),
    .zero_flag(zero_flag),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .reg_we(reg_we), .flag_we(flag_we), .pc(pc), .state(state), .retired(retired),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int kind, logic [3:0] bt, logic [15:0] off, logic zf, logic fw,
                              logic xrw, int idly, int ddly, logic [15:0] rd, logic [15:0] epc,
                              int elat, int erwe, int efwe, int edc);
    vec_t v;
    v.kind = kind; v.btype = bt; v.off = off; v.zf = zf; v.fw = fw; v.xrw = xrw;
    v.idly = idly; v.ddly = ddly; v.rdata = rd; v.exp_pc = epc; v.exp_lat = elat;
    v.exp_rwe = erwe; v.exp_fwe = efwe; v.exp_dcyc = edc;
    return v;
  endfunction

  // Reference model: instruction-level effect and cycle cost.
  function automatic vec_t model(vec_t v, logic [15:0] cur);
    bit taken;
    bit is_mem;
    int base;
    taken  = (v.btype == 4'd9) || (v.btype == 4'd10 && v.zf) || (v.btype == 4'd11 && !v.zf);
    is_mem = (v.kind == K_LOAD) || (v.kind == K_STORE);
    v.exp_pc = cur + 16'd1;
    if (v.kind == K_BR && taken) v.exp_pc = v.exp_pc + v.off;
    case (v.kind)
      K_ALU:   base = 4;
      K_LOAD:  base = 5;
      K_STORE: base = 4;
      default: base = 3;
    endcase
    v.exp_lat  = base + v.idly + (is_mem ? v.ddly : 0);
    v.exp_rwe  = (v.kind == K_ALU || v.kind == K_LOAD) ? 1 : 0;
    v.exp_fwe  = v.fw ? 1 : 0;
    v.exp_dcyc = is_mem ? v.ddly + 1 : 0;
    return v;
  endfunction

  task automatic set_ctl(input vec_t v);
    reg_write     = (v.kind == K_ALU) || (v.kind == K_LOAD) || (v.kind == K_BR && v.xrw);
    mem_read      = (v.kind == K_LOAD);
    mem_write     = (v.kind == K_STORE);
    flag_write    = v.fw;
    is_branch     = (v.kind == K_BR);
    branch_type   = v.btype;
    branch_offset = v.off;
    zero_flag     = v.zf;
  endtask

  task automatic wait_req(input string tag, output bit ok);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (imem_req === 1'b1);
    if (!ok) chk({tag, "_req_wait"}, 32'd0, 32'd1);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int cyc, rwe, fwe, dcyc, dk;
    bit ok, seen, we_bad;
    set_ctl(v);
    stall = 1'b0;
    wait_req(tag, ok);
    if (!ok) return;
    chk({tag, "_fetch_addr"}, imem_addr, m_pc);
    cyc = 0;
    for (int k = 0; k <= v.idly; k++) begin
      imem_ack   = (k == v.idly);
      imem_rdata = v.rdata;
      @(posedge clk); #1;
      imem_ack = 1'b0;
      cyc++;
    end
    chk({tag, "_instr"}, instruction, v.rdata);
    rwe = 0; fwe = 0; dcyc = 0; dk = 0; seen = 0; we_bad = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (imem_req === 1'b1) begin
        seen = 1;
      end else begin
        if (reg_we) rwe++;
        if (flag_we) fwe++;
        if (dmem_req) begin
          dcyc++;
          if (dmem_we !== (v.kind == K_STORE)) we_bad = 1;
          dmem_ack = (dk == v.ddly);
          dk++;
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        cyc++;
      end
    end
    chk({tag, "_next_fetch"}, seen, 1);
    chk({tag, "_latency"}, cyc, v.exp_lat);
    chk({tag, "_reg_we"}, rwe, v.exp_rwe);
    chk({tag, "_flag_we"}, fwe, v.exp_fwe);
    chk({tag, "_dmem_cyc"}, dcyc, v.exp_dcyc);
    chk({tag, "_dmem_we"}, we_bad, 0);
    m_pc  = v.exp_pc;
    m_ret = m_ret + 16'd1;
    chk({tag, "_pc"}, pc, m_pc);
    chk({tag, "_retired"}, retired, m_ret);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_pc  = 16'h0000;
    m_ret = 16'h0000;
  endtask

  initial begin
    int cnt;
    bit ok;
    vec_t v;
    rst_n = 1'b0; stall = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0; dmem_ack = 1'b0;
    reg_write = 0; mem_read = 0; mem_write = 0; flag_write = 0; is_branch = 0;
    branch_type = 4'h0; branch_offset = 16'h0; zero_flag = 0;

    tbl[0]  = mk(K_ALU,   4'h0, 16'h0000, 0, 0, 0, 0, 0, 16'h0650, 16'h0001, 4, 1, 0, 0);
    tbl[1]  = mk(K_ALU,   4'h0, 16'h0000, 0, 1, 0, 2, 0, 16'h1234, 16'h0002, 6, 1, 1, 0);
    tbl[2]  = mk(K_CMP,   4'h0, 16'h0000, 0, 1, 0, 0, 0, 16'h2001, 16'h0003, 3, 0, 1, 0);
    tbl[3]  = mk(K_CMP,   4'h0, 16'h0000, 1, 1, 0, 1, 0, 16'h2002, 16'h0004, 4, 0, 1, 0);
    tbl[4]  = mk(K_BR,    4'h9, 16'h000A, 0, 0, 1, 0, 0, 16'h900A, 16'h000F, 3, 0, 0, 0);
    tbl[5]  = mk(K_ALU,   4'h0, 16'h0000, 0, 0, 0, 0, 0, 16'h0651, 16'h0010, 4, 1, 0, 0);
    tbl[6]  = mk(K_BR,    4'h9, 16'hFFFC, 0, 0, 0, 0, 0, 16'h9FFC, 16'h000D, 3, 0, 0, 0);
    tbl[7]  = mk(K_BR,    4'hA, 16'h0014, 0, 0, 0, 0, 0, 16'hA014, 16'h000E, 3, 0, 0, 0);
    tbl[8]  = mk(K_BR,    4'hA, 16'h0014, 1, 0, 0, 0, 0, 16'hA014, 16'h0023, 3, 0, 0, 0);
    tbl[9]  = mk(K_BR,    4'hB, 16'hFFF8, 0, 0, 0, 0, 0, 16'hBFF8, 16'h001C, 3, 0, 0, 0);
    tbl[10] = mk(K_BR,    4'hB, 16'hFFF8, 1, 0, 0, 0, 0, 16'hBFF8, 16'h001D, 3, 0, 0, 0);
    tbl[11] = mk(K_BR,    4'h5, 16'h0100, 1, 0, 0, 0, 0, 16'h5100, 16'h001E, 3, 0, 0, 0);
    tbl[12] = mk(K_LOAD,  4'h0, 16'h0000, 0, 0, 0, 0, 3, 16'h410A, 16'h001F, 8, 1, 0, 4);
    tbl[13] = mk(K_STORE, 4'h0, 16'h0000, 0, 0, 0, 0, 0, 16'h510A, 16'h0020, 4, 0, 0, 1);
    tbl[14] = mk(K_STORE, 4'h0, 16'h0000, 0, 1, 0, 0, 2, 16'h520B, 16'h0021, 6, 0, 1, 3);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_instr", instruction, 16'h0000);
    chk("rst_retired", retired, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    rst_n = 1'b1;
    m_pc = 16'h0000; m_ret = 16'h0000;

    for (int i = 0; i < 15; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

    // Reset asserted while a load waits in MEM; stall held so FETCH idles afterwards
    set_ctl(mk(K_LOAD, 4'h0, 16'h0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0));
    wait_req("rstmem", ok);
    imem_ack = 1'b1; imem_rdata = 16'h4100;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rstmem_in_mem", state, 3);
    chk("rstmem_dreq_before", dmem_req, 1);
    rst_n = 1'b0; stall = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rstmem_dreq", dmem_req, 0);
    chk("rstmem_pc", pc, 16'h0000);
    chk("rstmem_state", state, 0);
    chk("rstmem_retired", retired, 0);
    m_pc = 16'h0000; m_ret = 16'h0000;

    // Stall: no request while stalled; once raised the request ignores stall
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("stall_idle_req", imem_req, 0);
    end
    stall = 1'b0;
    @(posedge clk); #1;
    chk("stall_release_req", imem_req, 1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_hold_req", imem_req, 1);
    end
    set_ctl(mk(K_ALU, 4'h0, 16'h0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0));
    imem_ack = 1'b1; imem_rdata = 16'h0650;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stall_after_state", state, 0);
    chk("stall_after_req", imem_req, 0);
    chk("stall_after_pc", pc, 16'h0001);
    chk("stall_after_retired", retired, 1);
    stall = 1'b0;

    // Fetch timeout: no ack ever
    do_reset();
    wait_req("tmo", ok);
    cnt = 0;
    while (imem_req === 1'b1 && cnt < 20) begin
      cnt++;
      @(posedge clk); #1;
    end
    chk("tmo_req_cycles", cnt, 8);
    chk("tmo_bus_err", bus_err, 1);
    chk("tmo_state", state, 7);
    imem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    imem_ack = 1'b0;
    chk("halt_state", state, 7);
    chk("halt_req", imem_req, 0);
    chk("halt_pc", pc, 16'h0000);
    chk("halt_retired", retired, 0);
    do_reset();
    chk("halt_rst_state", state, 0);
    chk("halt_rst_bus_err", bus_err, 0);

    // Ack arriving on the last permitted cycle wins over the timeout
    run_vec("late_ack", mk(K_ALU, 4'h0, 16'h0, 0, 0, 0, 7, 0, 16'h0777, 16'h0001, 11, 1, 0, 0));
    chk("late_ack_bus_err", bus_err, 0);

    // Random instructions against the model
    for (int i = 0; i < 150; i++) begin
      v.kind  = $urandom_range(0, 4);
      case ($urandom_range(0, 3))
        0: v.btype = 4'h9;
        1: v.btype = 4'hA;
        2: v.btype = 4'hB;
        default: v.btype = 4'($urandom);
      endcase
      v.off   = 16'($urandom);
      v.zf    = 1'($urandom);
      v.fw    = 1'($urandom);
      v.xrw   = 1'($urandom);
      v.idly  = $urandom_range(0, 7);
      v.ddly  = $urandom_range(0, 7);
      v.rdata = 16'($urandom);
      v = model(v, m_pc);
      run_vec($sformatf("rnd%0d", i), v);
    end
    chk("rnd_bus_err", bus_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
